// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks entries done on write-back,
// retires the head in program order and clears everything when a mispredicted branch retires.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic             alloc_uses_rw,
  input  logic [5:0]       alloc_rw,
  input  logic             alloc_is_branch,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic             cmpl_mispredict,
  output logic             retired_uses_rw,
  output logic [5:0]       retired_rw,
  output logic             retire_valid,
  output logic             flush,
  output logic [TAG_W:0]   count
);

  logic [TAG_W:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, mispred_q, mispred_d;
  logic [DEPTH-1:0] uses_rw_q, is_branch_q;
  logic [5:0]       rw_q [DEPTH];

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, retire_en, flush_pending, alloc_fire, cmpl_fire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full          = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign retire_en     = valid_q[head_idx] & done_q[head_idx];
  assign flush_pending = retire_en & mispred_q[head_idx];
  assign alloc_ready   = !full && !flush_pending;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign cmpl_fire     = cmpl_valid && valid_q[cmpl_tag] && !flush_pending;

  assign alloc_tag = tail_idx;
  assign count     = tail_q - head_q;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    head_d    = head_q + {{TAG_W{1'b0}}, retire_en};
    tail_d    = tail_q + {{TAG_W{1'b0}}, alloc_fire};

    if (cmpl_fire) begin
      done_d[cmpl_tag]    = 1'b1;
      mispred_d[cmpl_tag] = cmpl_mispredict & is_branch_q[cmpl_tag];
    end
    if (retire_en) begin
      valid_d[head_idx] = 1'b0;
    end
    // Alloc never targets a live slot: the tail slot is free unless full.
    if (alloc_fire) begin
      valid_d[tail_idx]   = 1'b1;
      done_d[tail_idx]    = 1'b0;
      mispred_d[tail_idx] = 1'b0;
    end
    if (flush_pending) begin
      valid_d = '0;
      tail_d  = head_q + {{TAG_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
    end
  end

  // Payload fields are only meaningful while the slot is valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      uses_rw_q[tail_idx]   <= alloc_uses_rw;
      is_branch_q[tail_idx] <= alloc_is_branch;
      rw_q[tail_idx]        <= alloc_rw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid    <= 1'b0;
      retired_uses_rw <= 1'b0;
      retired_rw      <= '0;
      flush           <= 1'b0;
    end else begin
      retire_valid    <= retire_en;
      retired_uses_rw <= retire_en & uses_rw_q[head_idx];
      retired_rw      <= retire_en ? rw_q[head_idx] : '0;
      flush           <= flush_pending;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_valid = 1'b0, alloc_ready, alloc_uses_rw = 1'b0, alloc_is_branch = 1'b0;
  logic [5:0]       alloc_rw = '0;
  logic [TAG_W-1:0] alloc_tag, cmpl_tag = '0;
  logic             cmpl_valid = 1'b0, cmpl_mispredict = 1'b0;
  logic             retired_uses_rw, retire_valid, flush;
  logic [5:0]       retired_rw;
  logic [TAG_W:0]   count;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uses_rw(alloc_uses_rw),
    .alloc_rw(alloc_rw), .alloc_is_branch(alloc_is_branch), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_mispredict(cmpl_mispredict),
    .retired_uses_rw(retired_uses_rw), .retired_rw(retired_rw), .retire_valid(retire_valid),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    bit         uses;
    logic [5:0] rw;
    bit         br;
    bit         done;
    bit         misp;
  } ent_t;

  ent_t q[$];   // live entries, oldest first
  int   next_tag;
  int   checks = 0;
  int   errors = 0;

  logic             e_ready, e_rv, e_ru, e_fl;
  logic [TAG_W-1:0] e_tag;
  logic [5:0]       e_rw;
  logic [TAG_W:0]   e_cnt;
  logic             o_ready;
  logic [TAG_W-1:0] o_tag;

  task automatic model_reset();
    q.delete();
    next_tag = 0;
  endtask

  task automatic do_reset();
    alloc_valid = 0; cmpl_valid = 0; cmpl_mispredict = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  // Drive one cycle of stimulus and advance the model across the same edge.
  task automatic cycle(input bit av, input bit au, input logic [5:0] arw, input bit ab,
                       input bit cv, input int ct, input bit cm);
    bit   ret, fl, fire;
    int   hd;
    ent_t e;
    alloc_valid = av; alloc_uses_rw = au; alloc_rw = arw; alloc_is_branch = ab;
    cmpl_valid = cv; cmpl_tag = TAG_W'(ct); cmpl_mispredict = cm;
    e_ready = (q.size() < DEPTH) && !(q.size() > 0 && q[0].done && q[0].misp);
    e_tag   = TAG_W'(next_tag);
    #1;
    o_ready = alloc_ready;
    o_tag   = alloc_tag;
    @(posedge clk);
    #1;
    ret  = (q.size() > 0) && q[0].done;
    fl   = ret && q[0].misp;
    fire = av && e_ready;
    hd   = 0;
    if (cv && !fl)
      foreach (q[i]) if (q[i].tag == (ct % DEPTH)) begin
        q[i].done = 1;
        q[i].misp = cm && q[i].br;
      end
    e_rv = ret;
    e_ru = ret && q[0].uses;
    e_rw = ret ? q[0].rw : 6'd0;
    e_fl = fl;
    if (ret) begin
      hd = q[0].tag;
      void'(q.pop_front());
    end
    if (fl) begin
      q.delete();
      next_tag = (hd + 1) % DEPTH;
    end
    if (fire) begin
      e.tag = next_tag; e.uses = au; e.rw = arw; e.br = ab; e.done = 0; e.misp = 0;
      q.push_back(e);
      next_tag = (next_tag + 1) % DEPTH;
    end
    e_cnt = (TAG_W + 1)'(q.size());
    alloc_valid = 0; cmpl_valid = 0; cmpl_mispredict = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({retire_valid, retired_uses_rw, retired_rw, flush, count, alloc_ready, alloc_tag}
        !== {1'b0, 1'b0, 6'd0, 1'b0, 5'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: got rv=%b ru=%b rw=%0d fl=%b cnt=%0d rdy=%b tag=%0d, want 0 0 0 0 0 1 0",
               retire_valid, retired_uses_rw, retired_rw, flush, count, alloc_ready, alloc_tag);
    end
    do_reset();
  endtask

  task automatic test_in_order();
    bit         av_t[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [5:0] rw_t[10] = '{5, 6, 7, 0, 0, 0, 0, 0, 0, 0};
    bit         cv_t[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int         ct_t[10] = '{0, 0, 0, 2, 1, 0, 0, 0, 0, 0};
    logic [5:0] order[$];
    for (int c = 0; c < 10; c++) begin
      cycle(av_t[c], 1, rw_t[c], 0, cv_t[c], ct_t[c], 0);
      checks++;
      if ({retire_valid, retired_uses_rw, retired_rw, flush, count} !== {e_rv, e_ru, e_rw, e_fl, e_cnt}) begin
        errors++;
        $display("FAIL in_order cyc%0d: got rv=%b ru=%b rw=%0d fl=%b cnt=%0d want rv=%b ru=%b rw=%0d fl=%b cnt=%0d",
                 c, retire_valid, retired_uses_rw, retired_rw, flush, count, e_rv, e_ru, e_rw, e_fl, e_cnt);
      end
      if (c < 3) begin
        checks++;
        if (o_tag !== e_tag) begin
          errors++;
          $display("FAIL in_order_tag cyc%0d: got %0d want %0d", c, o_tag, e_tag);
        end
      end
      if (retire_valid === 1'b1) order.push_back(retired_rw);
      if (c == 5) begin
        checks++;
        if (retire_valid !== 1'b0) begin
          errors++;
          $display("FAIL in_order_latency: retire_valid=%b on completion edge, want 0", retire_valid);
        end
      end
    end
    checks++;
    if (order.size() != 3 || order[0] !== 6'd5 || order[1] !== 6'd6 || order[2] !== 6'd7) begin
      errors++;
      $display("FAIL in_order_sequence: got %0d retirements %p, want 5 6 7", order.size(), order);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      cycle(1, 1, 6'($urandom_range(0, 63)), 0, 0, 0, 0);
      checks++;
      if (count !== e_cnt || o_tag !== e_tag) begin
        errors++;
        $display("FAIL full_fill cyc%0d: got cnt=%0d tag=%0d want cnt=%0d tag=%0d", c, count, o_tag, e_cnt, e_tag);
      end
    end
    checks++;
    if (count !== 5'd16 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got cnt=%0d rdy=%b want cnt=16 rdy=0", count, alloc_ready);
    end
    cycle(1, 1, 6'd1, 0, 1, 0, 0);   // dropped alloc, completes tag 0
    checks++;
    if (o_ready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_drop: got rdy=%b cnt=%0d want rdy=0 cnt=16", o_ready, count);
    end
    cycle(1, 1, 6'd2, 0, 0, 0, 0);   // head retires here; still full before the edge
    checks++;
    if (o_ready !== 1'b0 || retire_valid !== 1'b1 || count !== e_cnt) begin
      errors++;
      $display("FAIL full_no_bypass: got rdy=%b rv=%b cnt=%0d want rdy=0 rv=1 cnt=%0d", o_ready, retire_valid, count, e_cnt);
    end
    cycle(1, 1, 6'd3, 0, 0, 0, 0);
    checks++;
    if (o_ready !== 1'b1 || o_tag !== 4'd0 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_realloc: got rdy=%b tag=%0d cnt=%0d want rdy=1 tag=0 cnt=16", o_ready, o_tag, count);
    end
    for (int n = 0; n < 200 && q.size() > 0; n++) begin
      cycle(0, 0, 0, 0, 1, q[$urandom_range(0, q.size() - 1)].tag, 0);
      checks++;
      if ({retire_valid, retired_uses_rw, retired_rw, flush, count} !== {e_rv, e_ru, e_rw, e_fl, e_cnt}) begin
        errors++;
        $display("FAIL full_drain n%0d: got rv=%b ru=%b rw=%0d fl=%b cnt=%0d want rv=%b ru=%b rw=%0d fl=%b cnt=%0d",
                 n, retire_valid, retired_uses_rw, retired_rw, flush, count, e_rv, e_ru, e_rw, e_fl, e_cnt);
      end
    end
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL full_drained: got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 1, 6'd1, 1, 0, 0, 0);
    cycle(1, 1, 6'd2, 0, 0, 0, 0);
    cycle(1, 1, 6'd3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0, 1);
    cycle(1, 1, 6'd9, 0, 1, 2, 0);   // flush edge: alloc and completion both ignored
    checks++;
    if (o_ready !== 1'b0 || retire_valid !== 1'b1 || flush !== 1'b1 || retired_rw !== 6'd1
        || count !== 5'd0) begin
      errors++;
      $display("FAIL flush_pulse: got rdy=%b rv=%b fl=%b rw=%0d cnt=%0d want rdy=0 rv=1 fl=1 rw=1 cnt=0",
               o_ready, retire_valid, flush, retired_rw, count);
    end
    cycle(1, 1, 6'd4, 0, 1, 2, 0);
    checks++;
    if (o_tag !== 4'd1 || flush !== 1'b0 || retire_valid !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL flush_after: got tag=%0d fl=%b rv=%b cnt=%0d want tag=1 fl=0 rv=0 cnt=1",
               o_tag, flush, retire_valid, count);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 0, 0, c == 1, 1, 0);
      checks++;
      if ({retire_valid, retired_uses_rw, retired_rw, flush, count} !== {e_rv, e_ru, e_rw, e_fl, e_cnt}) begin
        errors++;
        $display("FAIL flush_resume cyc%0d: got rv=%b ru=%b rw=%0d fl=%b cnt=%0d want rv=%b ru=%b rw=%0d fl=%b cnt=%0d",
                 c, retire_valid, retired_uses_rw, retired_rw, flush, count, e_rv, e_ru, e_rw, e_fl, e_cnt);
      end
    end
  endtask

  task automatic test_no_rw();
    int t;
    t = next_tag;
    cycle(1, 0, 6'd9, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, t, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (retire_valid !== 1'b1 || retired_uses_rw !== 1'b0 || retired_rw !== 6'd9) begin
      errors++;
      $display("FAIL no_rw: got rv=%b ru=%b rw=%0d want rv=1 ru=0 rw=9", retire_valid, retired_uses_rw, retired_rw);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit av, cv;
      int ct;
      av = $urandom_range(0, 99) < 60;
      cv = (q.size() > 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 10);
      ct = (q.size() > 0 && $urandom_range(0, 4) != 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                                       : int'($urandom_range(0, DEPTH - 1));
      cycle(av, 1'($urandom), 6'($urandom), $urandom_range(0, 3) == 0, cv, ct, $urandom_range(0, 9) == 0);
      checks++;
      if ({o_ready, retire_valid, retired_uses_rw, retired_rw, flush, count}
          !== {e_ready, e_rv, e_ru, e_rw, e_fl, e_cnt} || (av && e_ready && o_tag !== e_tag)) begin
        errors++;
        $display("FAIL random cyc%0d: got rdy=%b tag=%0d rv=%b ru=%b rw=%0d fl=%b cnt=%0d want rdy=%b tag=%0d rv=%b ru=%b rw=%0d fl=%b cnt=%0d",
                 c, o_ready, o_tag, retire_valid, retired_uses_rw, retired_rw, flush, count,
                 e_ready, e_tag, e_rv, e_ru, e_rw, e_fl, e_cnt);
      end
      checks++;
      if (count > 5'd16) begin
        errors++;
        $display("FAIL random_bound cyc%0d: got cnt=%0d want <=16", c, count);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) cycle(1, 1, 6'(20 + c), 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) cycle(0, 0, 0, 0, 1, c, 0);
    checks++;
    if (retire_valid !== 1'b1 || count !== e_cnt) begin
      errors++;
      $display("FAIL async_pre: got rv=%b cnt=%0d want rv=1 cnt=%0d", retire_valid, count, e_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({retire_valid, retired_uses_rw, retired_rw, flush, count, alloc_ready}
        !== {1'b0, 1'b0, 6'd0, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got rv=%b ru=%b rw=%0d fl=%b cnt=%0d rdy=%b want 0 0 0 0 0 1",
               retire_valid, retired_uses_rw, retired_rw, flush, count, alloc_ready);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (alloc_tag !== 4'd0 || count !== 5'd0 || retire_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got tag=%0d cnt=%0d rv=%b want 0 0 0", alloc_tag, count, retire_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_no_rw();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
